// File: rtl/spi_peripheral_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
// Readback of registers over CIPO is enabled with the SPI_READBACK_EN macro.
package spi_peripheral_pkg;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   localparam int unsigned FRAME_BITS = 16;
   localparam logic [4:0]  CNT_SAT    = 5'd17;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall pulses
// derived from the synchronized level only.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Chain resets low so a line already low at reset release produces no
   // falling edge; a full high-then-low sequence is needed to open a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every stage sampling the old value of its neighbour.
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 register peripheral: 16-bit write frames {R/W, addr[6:0], data[7:0]}
// into five 8-bit control registers. Define SPI_READBACK_EN to enable reads on CIPO.
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       nCS,
   input  logic       SCLK,
   input  logic       COPI,
   output logic       CIPO,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   logic ncs_level_unused, ncs_rise, ncs_fall;
   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic copi_s, copi_rise_unused, copi_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d(nCS),
      .q(ncs_level_unused), .rise(ncs_rise), .fall(ncs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d(SCLK),
      .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d(COPI),
      .q(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   spi_state_t  state;
   logic [4:0]  bit_cnt;
   logic [15:0] shift_q;
   logic        frame_ok;

   assign frame_ok = (bit_cnt == 5'(FRAME_BITS)) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

`ifdef SPI_READBACK_EN
   logic [7:0] hdr_q;
   logic [7:0] rd_data;
   logic       cipo_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd_data = 8'h00;
      case (hdr_q[6:0])
         ADDR_EN_OUT_7_0:  rd_data = en_reg_out_7_0;
         ADDR_EN_OUT_15_8: rd_data = en_reg_out_15_8;
         ADDR_EN_PWM_7_0:  rd_data = en_reg_pwm_7_0;
         ADDR_EN_PWM_15_8: rd_data = en_reg_pwm_15_8;
         ADDR_PWM_DUTY:    rd_data = pwm_duty_cycle;
         default:          rd_data = 8'h00;
      endcase
   end

   assign CIPO = cipo_q;
`else
   assign CIPO = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         bit_cnt         <= '0;
         shift_q         <= '0;
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
`ifdef SPI_READBACK_EN
         hdr_q           <= 8'h00;
         cipo_q          <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (ncs_fall) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  shift_q <= '0;
`ifdef SPI_READBACK_EN
                  hdr_q   <= 8'h00;
`endif
               end
            end
            ST_SHIFT: begin
               // A last SCLK edge coinciding with nCS release is still counted.
               if (sclk_rise) begin
                  shift_q <= {shift_q[14:0], copi_s};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
`ifdef SPI_READBACK_EN
                  if (bit_cnt == 5'd7) hdr_q <= {shift_q[6:0], copi_s};
`endif
               end
`ifdef SPI_READBACK_EN
               if (sclk_fall) begin
                  if (bit_cnt >= 5'd8 && bit_cnt < 5'd16 && !hdr_q[7] && hdr_q[6:0] <= MAX_ADDR)
                     cipo_q <= rd_data[~bit_cnt[2:0]];
                  else
                     cipo_q <= 1'b0;
               end
               if (ncs_rise) cipo_q <= 1'b0;
`endif
               if (ncs_rise) state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               state <= ST_IDLE;
               if (frame_ok) begin
                  case (shift_q[14:8])
                     ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shift_q[7:0];
                     ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shift_q[7:0];
                     ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shift_q[7:0];
                     ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shift_q[7:0];
                     ADDR_PWM_DUTY:    pwm_duty_cycle  <= shift_q[7:0];
                     default: ;
                  endcase
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral (SYNC_STAGES=2, MAX_ADDR=0x04).
// Readback expectations follow the SPI_READBACK_EN macro.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       nCS = 1'b1;
   logic       SCLK = 1'b0;
   logic       COPI = 1'b0;
   logic       CIPO;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

   int errors = 0;
   int checks = 0;

   spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
      .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Order: {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}
   function automatic logic [39:0] regs_now();
      return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period with 4-clk phases; CIPO captured just before the rising edge.
   task automatic send_bit(input logic b, output logic c);
      COPI = b;
      wait_clks(4);
      c = CIPO;
      SCLK = 1'b1;
      wait_clks(4);
      SCLK = 1'b0;
   endtask

   task automatic spi_xfer(input logic [31:0] word, input int nbits, output logic [15:0] cap);
      logic c;
      cap = 16'h0000;
      nCS = 1'b0;
      wait_clks(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         send_bit(word[i], c);
         if (i < 16) cap[i] = c;
      end
      wait_clks(4);
      nCS = 1'b1;
   endtask

   task automatic test_reset();
      logic [15:0] cap;
      nCS = 1'b0;
      wait_clks(3);
      checks++;
      if (regs_now() !== 40'h0 || CIPO !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: regs=%h cipo=%b expected regs=%h cipo=0", regs_now(), CIPO, 40'h0);
      end
      rst_n = 1'b1;
      wait_clks(2);
      // nCS already low at release: this frame has no falling edge and must be ignored.
      spi_xfer(32'h8055, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'h0) begin
         errors++;
         $display("FAIL no_frame_after_reset_low_ncs: regs=%h expected %h", regs_now(), 40'h0);
      end
   endtask

   task automatic test_pwm_write();
      logic [15:0] cap;
      spi_xfer(32'h8480, 16, cap);
      wait_clks(3);
      checks++;
      if (pwm_duty_cycle !== 8'h00) begin
         errors++;
         $display("FAIL commit_not_early: duty=%h expected 00 after 3 edges", pwm_duty_cycle);
      end
      wait_clks(1);
      checks++;
      if (pwm_duty_cycle !== 8'h80) begin
         errors++;
         $display("FAIL commit_latency: duty=%h expected 80 after 4 edges", pwm_duty_cycle);
      end
      wait_clks(4);
      checks++;
      if (regs_now() !== 40'h00_00_00_00_80) begin
         errors++;
         $display("FAIL pwm_write: regs=%h expected %h", regs_now(), 40'h00_00_00_00_80);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] cap;
      spi_xfer(32'h80F0, 16, cap);
      wait_clks(6);
      spi_xfer(32'h830F, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_00_00_0F_80) begin
         errors++;
         $display("FAIL back_to_back: regs=%h expected %h", regs_now(), 40'hF0_00_00_0F_80);
      end
   endtask

   task automatic test_bad_addr();
      logic [15:0] cap;
      spi_xfer(32'hB0AA, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_00_00_0F_80) begin
         errors++;
         $display("FAIL addr_0x30_ignored: regs=%h expected %h", regs_now(), 40'hF0_00_00_0F_80);
      end
      spi_xfer(32'h8555, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_00_00_0F_80) begin
         errors++;
         $display("FAIL addr_0x05_ignored: regs=%h expected %h", regs_now(), 40'hF0_00_00_0F_80);
      end
   endtask

   task automatic test_frame_len();
      logic [15:0] cap;
      spi_xfer(32'h409E, 15, cap);
      wait_clks(6);
      checks++;
      if (en_reg_out_15_8 !== 8'h00) begin
         errors++;
         $display("FAIL frame_15_bits: out_15_8=%h expected 00", en_reg_out_15_8);
      end
      spi_xfer(32'h10279, 17, cap);
      wait_clks(6);
      checks++;
      if (en_reg_out_15_8 !== 8'h00) begin
         errors++;
         $display("FAIL frame_17_bits: out_15_8=%h expected 00", en_reg_out_15_8);
      end
      spi_xfer(32'h813C, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_3C_00_0F_80) begin
         errors++;
         $display("FAIL frame_16_bits: regs=%h expected %h", regs_now(), 40'hF0_3C_00_0F_80);
      end
      spi_xfer(32'h0011, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_3C_00_0F_80) begin
         errors++;
         $display("FAIL read_frame_no_write: regs=%h expected %h", regs_now(), 40'hF0_3C_00_0F_80);
      end
   endtask

   task automatic test_readback();
      logic [15:0] cap;
      logic [15:0] exp_cap;
      spi_xfer(32'h82A5, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'hF0_3C_A5_0F_80) begin
         errors++;
         $display("FAIL write_a5: regs=%h expected %h", regs_now(), 40'hF0_3C_A5_0F_80);
      end
`ifdef SPI_READBACK_EN
      exp_cap = 16'h00A5;
`else
      exp_cap = 16'h0000;
`endif
      spi_xfer(32'h0200, 16, cap);
      wait_clks(6);
      checks++;
      if (cap !== exp_cap) begin
         errors++;
         $display("FAIL readback_cipo: got %h expected %h", cap, exp_cap);
      end
      checks++;
      if (CIPO !== 1'b0 || regs_now() !== 40'hF0_3C_A5_0F_80) begin
         errors++;
         $display("FAIL after_read: cipo=%b regs=%h expected cipo=0 regs=%h", CIPO, regs_now(), 40'hF0_3C_A5_0F_80);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] word;
      logic [15:0] cap;
      logic        c;
      word = 16'h82FF;
      nCS = 1'b0;
      wait_clks(4);
      for (int i = 15; i >= 6; i--) send_bit(word[i], c);
      rst_n = 1'b0;
      #1;
      checks++;
      if (regs_now() !== 40'h0 || CIPO !== 1'b0) begin
         errors++;
         $display("FAIL reset_immediate: regs=%h cipo=%b expected regs=%h cipo=0", regs_now(), CIPO, 40'h0);
      end
      wait_clks(2);
      rst_n = 1'b1;
      for (int i = 5; i >= 0; i--) send_bit(word[i], c);
      wait_clks(4);
      nCS = 1'b1;
      wait_clks(6);
      checks++;
      if (en_reg_pwm_7_0 !== 8'h00 || regs_now() !== 40'h0) begin
         errors++;
         $display("FAIL no_partial_commit: regs=%h expected %h", regs_now(), 40'h0);
      end
      spi_xfer(32'h8233, 16, cap);
      wait_clks(6);
      checks++;
      if (regs_now() !== 40'h00_00_33_00_00) begin
         errors++;
         $display("FAIL recover_after_reset: regs=%h expected %h", regs_now(), 40'h00_00_33_00_00);
      end
   endtask

   initial begin
      test_reset();
      test_pwm_write();
      test_back_to_back();
      test_bad_addr();
      test_frame_len();
      test_readback();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
